// File: rtl/banzai_axil_responder.sv
// ---------------------------------------------------------------------------
// banzai_axil_responder
//
// AXI-Lite responder backed by a DEPTH x 32-bit register-file memory. It
// serves the banzAI master port.
//
// Parameters
//   BASE_ADDR : first byte address decoded by the block
//   DEPTH     : number of 32-bit words (power of two, >= 2)
//
// Ports
//   clk_i, rst_i               : single rising-edge clock, sync active-high reset
//   s_aw*                      : write address channel (awprot ignored)
//   s_w*                       : write data channel with byte strobes
//   s_b*                       : write response channel (OKAY / SLVERR)
//   s_ar*                      : read address channel (arprot ignored)
//   s_r*                       : read data channel (OKAY / SLVERR, data 0 on error)
//
// Write path: AW and W land in independent one-entry holders, so they can
// arrive in any order. The write commits once both holders are full and no
// B response is outstanding; the holders may refill while B waits.
// Read path: one outstanding read; arready is simply !rvalid.
// ---------------------------------------------------------------------------
module banzai_axil_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // write address
  input  logic [31:0] s_awaddr_i,
  input  logic [2:0]  s_awprot_i,
  input  logic        s_awvalid_i,
  output logic        s_awready_o,
  // write data
  input  logic [31:0] s_wdata_i,
  input  logic [3:0]  s_wstrb_i,
  input  logic        s_wvalid_i,
  output logic        s_wready_o,
  // write response
  output logic [1:0]  s_bresp_o,
  output logic        s_bvalid_o,
  input  logic        s_bready_i,
  // read address
  input  logic [31:0] s_araddr_i,
  input  logic [2:0]  s_arprot_i,
  input  logic        s_arvalid_i,
  output logic        s_arready_o,
  // read data
  output logic [31:0] s_rdata_o,
  output logic [1:0]  s_rresp_o,
  output logic        s_rvalid_o,
  input  logic        s_rready_i
);

  localparam int         IDX_W = $clog2(DEPTH);
  // Byte span of the memory; one extra bit so a full 4 GiB span cannot wrap.
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] mem [DEPTH];

  // Protection attributes carry no meaning for this memory.
  logic unused_prot;
  assign unused_prot = ^{s_awprot_i, s_arprot_i};

  // Address decode. The subtraction wraps, so addresses below BASE_ADDR
  // become huge offsets and fall out of range naturally.
  logic [31:0]      aw_off, ar_off;
  logic             aw_hit, ar_hit;
  logic [IDX_W-1:0] aw_idx, ar_idx;

  always_comb begin
    aw_off = s_awaddr_i - BASE_ADDR;
    ar_off = s_araddr_i - BASE_ADDR;
    aw_hit = {1'b0, aw_off} < SPAN;
    ar_hit = {1'b0, ar_off} < SPAN;
    aw_idx = aw_off[IDX_W+1:2];
    ar_idx = ar_off[IDX_W+1:2];
  end

  // Holder state
  logic             aw_full, w_full;
  logic [IDX_W-1:0] aw_idx_q;
  logic             aw_hit_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;

  assign s_awready_o = ~aw_full;
  assign s_wready_o  = ~w_full;
  assign s_arready_o = ~s_rvalid_o;

  assign aw_hs  = s_awvalid_i & ~aw_full;
  assign w_hs   = s_wvalid_i & ~w_full;
  assign ar_hs  = s_arvalid_i & ~s_rvalid_o;
  assign b_hs   = s_bvalid_o & s_bready_i;
  assign r_hs   = s_rvalid_o & s_rready_i;
  // Reset suppresses the commit so no memory write happens in a reset cycle.
  assign commit = aw_full & w_full & ~s_bvalid_o & ~rst_i;

  // Control state and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_full    <= 1'b0;
      w_full     <= 1'b0;
      s_bvalid_o <= 1'b0;
      s_bresp_o  <= RESP_OKAY;
      s_rvalid_o <= 1'b0;
      s_rresp_o  <= RESP_OKAY;
      s_rdata_o  <= 32'h0;
    end else begin
      // A holder can only be loaded while empty and only commits while full,
      // so load and clear never coincide.
      if (commit)     aw_full <= 1'b0;
      else if (aw_hs) aw_full <= 1'b1;

      if (commit)    w_full <= 1'b0;
      else if (w_hs) w_full <= 1'b1;

      if (commit) begin
        s_bvalid_o <= 1'b1;
        s_bresp_o  <= aw_hit_q ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        s_bvalid_o <= 1'b0;
      end

      // The memory read samples the array before any same-edge commit lands,
      // so a colliding read returns pre-write data.
      if (ar_hs) begin
        s_rvalid_o <= 1'b1;
        s_rdata_o  <= ar_hit ? mem[ar_idx] : 32'h0;
        s_rresp_o  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (r_hs) begin
        s_rvalid_o <= 1'b0;
      end
    end
  end

  // Holder payloads carry no reset; they are qualified by aw_full / w_full.
  always_ff @(posedge clk_i) begin
    if (aw_hs) begin
      aw_idx_q <= aw_idx;
      aw_hit_q <= aw_hit;
    end
    if (w_hs) begin
      w_data_q <= s_wdata_i;
      w_strb_q <= s_wstrb_i;
    end
  end

  // Memory array (contents survive reset)
  always_ff @(posedge clk_i) begin
    if (commit && aw_hit_q) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) mem[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_banzai_axil_responder.sv
// ---------------------------------------------------------------------------
// tb_banzai_axil_responder
//
// Scoreboard bench: the stimulus side pushes expected B / R responses into
// queues (from a word-array reference model), and a monitor pops and
// compares whenever a response handshake is about to happen.
// ---------------------------------------------------------------------------
module tb_banzai_axil_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] s_awaddr_i = '0;
  logic [2:0]  s_awprot_i = '0;
  logic        s_awvalid_i = 1'b0;
  logic        s_awready_o;
  logic [31:0] s_wdata_i = '0;
  logic [3:0]  s_wstrb_i = '0;
  logic        s_wvalid_i = 1'b0;
  logic        s_wready_o;
  logic [1:0]  s_bresp_o;
  logic        s_bvalid_o;
  logic        s_bready_i = 1'b1;
  logic [31:0] s_araddr_i = '0;
  logic [2:0]  s_arprot_i = '0;
  logic        s_arvalid_i = 1'b0;
  logic        s_arready_o;
  logic [31:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_rvalid_o;
  logic        s_rready_i = 1'b1;

  always #5 clk = ~clk;

  banzai_axil_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_awaddr_i(s_awaddr_i), .s_awprot_i(s_awprot_i),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arprot_i(s_arprot_i),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];   // {rresp, rdata}
  logic [31:0] ref_mem [DEPTH];

  // 0: ready always high, 1: random, 2: held low
  int bready_mode = 0;
  int rready_mode = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DEPTH * 4);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (model_hit(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[model_idx(a)][8*b +: 8] = d[8*b +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic model_read(input logic [31:0] a);
    if (model_hit(a)) exp_r.push_back({2'b00, ref_mem[model_idx(a)]});
    else              exp_r.push_back({2'b10, 32'h0});
  endtask

  // ---------------- ready drivers ----------------
  always @(negedge clk) begin
    case (bready_mode)
      0:       s_bready_i = 1'b1;
      1:       s_bready_i = 1'($urandom_range(0, 1));
      default: s_bready_i = 1'b0;
    endcase
    case (rready_mode)
      0:       s_rready_i = 1'b1;
      1:       s_rready_i = 1'($urandom_range(0, 1));
      default: s_rready_i = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  logic        b_hold = 1'b0, r_hold = 1'b0;
  logic [1:0]  b_hold_resp;
  logic [33:0] r_hold_val;
  logic [1:0]  eb;
  logic [33:0] er;

  always begin
    @(negedge clk);
    #1;
    if (rst_i) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (b_hold) begin
        check("b_stable_valid", 34'(s_bvalid_o), 34'd1);
        check("b_stable_resp", 34'(s_bresp_o), 34'(b_hold_resp));
      end
      if (r_hold) begin
        check("r_stable_valid", 34'(s_rvalid_o), 34'd1);
        check("r_stable_data", {s_rresp_o, s_rdata_o}, r_hold_val);
      end
      if (s_bvalid_o && s_bready_i) begin
        if (exp_b.size() == 0) check("b_unexpected", 34'd1, 34'd0);
        else begin
          eb = exp_b.pop_front();
          check("bresp", 34'(s_bresp_o), 34'(eb));
        end
      end
      if (s_rvalid_o && s_rready_i) begin
        if (exp_r.size() == 0) check("r_unexpected", 34'd1, 34'd0);
        else begin
          er = exp_r.pop_front();
          check("rresp_rdata", {s_rresp_o, s_rdata_o}, er);
        end
      end
      b_hold      = s_bvalid_o && !s_bready_i;
      b_hold_resp = s_bresp_o;
      r_hold      = s_rvalid_o && !s_rready_i;
      r_hold_val  = {s_rresp_o, s_rdata_o};
    end
  end

  // ---------------- channel drivers ----------------
  task automatic aw_send(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    s_awaddr_i = a; s_awprot_i = 3'($urandom); s_awvalid_i = 1'b1;
    while (!s_awready_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("aw_accept_timeout", 34'(n), 34'd0);
    @(posedge clk); #1 s_awvalid_i = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    s_wdata_i = d; s_wstrb_i = s; s_wvalid_i = 1'b1;
    while (!s_wready_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("w_accept_timeout", 34'(n), 34'd0);
    @(posedge clk); #1 s_wvalid_i = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    s_araddr_i = a; s_arprot_i = 3'($urandom); s_arvalid_i = 1'b1;
    while (!s_arready_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("ar_accept_timeout", 34'(n), 34'd0);
    @(posedge clk); #1 s_arvalid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    check("responses_outstanding", 34'(exp_b.size() + exp_r.size()), 34'd0);
    exp_b.delete();
    exp_r.delete();
    @(negedge clk);
  endtask

  // order 0: AW first, 1: W first, other: same cycle
  task automatic write_issue(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int order);
    model_write(a, d, s);
    case (order)
      0: begin aw_send(a); repeat ($urandom_range(0, 2)) @(negedge clk); w_send(d, s); end
      1: begin w_send(d, s); repeat ($urandom_range(0, 2)) @(negedge clk); aw_send(a); end
      default: fork aw_send(a); w_send(d, s); join
    endcase
  endtask

  task automatic read_issue(input logic [31:0] a);
    model_read(a);
    ar_send(a);
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int order);
    write_issue(a, d, s, order);
    wait_idle();
  endtask

  task automatic read_txn(input logic [31:0] a);
    read_issue(a);
    wait_idle();
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] keep, d;
    int widx, ridx, n;

    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_awready", 34'(s_awready_o), 34'd1);
    check("rst_wready",  34'(s_wready_o),  34'd1);
    check("rst_arready", 34'(s_arready_o), 34'd1);
    check("rst_bvalid",  34'(s_bvalid_o),  34'd0);
    check("rst_rvalid",  34'(s_rvalid_o),  34'd0);
    check("rst_bresp",   34'(s_bresp_o),   34'd0);
    check("rst_rresp_rdata", {s_rresp_o, s_rdata_o}, 34'd0);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) write_txn(BASE + 32'(i * 4), $urandom, 4'hF, i % 3);

    // AW then W two cycles later; B and R latency.
    model_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    aw_send(32'h10);
    repeat (2) @(negedge clk);
    w_send(32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("b_latency_early", 34'(s_bvalid_o), 34'd0);
    @(negedge clk);
    check("b_latency", 34'(s_bvalid_o), 34'd1);
    check("b_latency_resp", 34'(s_bresp_o), 34'd0);
    wait_idle();
    exp_r.push_back({2'b00, 32'hDEAD_BEEF});
    ar_send(32'h10);
    @(negedge clk);
    check("r_latency", 34'(s_rvalid_o), 34'd1);
    wait_idle();

    // W before AW with partial strobes.
    write_txn(32'h14, 32'hFFFF_FFFF, 4'hF, 2);
    model_write(32'h14, 32'h1122_3344, 4'b0101);
    w_send(32'h1122_3344, 4'b0101);
    repeat (2) @(negedge clk);
    aw_send(32'h14);
    wait_idle();
    exp_r.push_back({2'b00, 32'hFF22_FF44});
    ar_send(32'h14);
    wait_idle();

    // Out-of-range write/read just past the end.
    keep = ref_mem[0];
    exp_b.push_back(2'b10);
    fork aw_send(BASE + 32'(DEPTH * 4)); w_send(32'h5555_AAAA, 4'hF); join
    wait_idle();
    exp_r.push_back({2'b10, 32'h0});
    ar_send(BASE + 32'(DEPTH * 4));
    wait_idle();
    exp_r.push_back({2'b00, keep});
    ar_send(BASE);
    wait_idle();

    // B back-pressure with a second write queued behind it.
    bready_mode = 2;
    @(negedge clk);
    write_issue(32'h8, $urandom, 4'hF, 2);
    n = 0;
    while (!s_bvalid_o && n < 20) begin @(negedge clk); n++; end
    check("bp_b_rise", 34'(s_bvalid_o), 34'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      check("bp_b_hold_valid", 34'(s_bvalid_o), 34'd1);
      check("bp_b_hold_resp", 34'(s_bresp_o), 34'd0);
    end
    write_issue(32'hC, $urandom, 4'hF, 2);
    @(negedge clk); #2;
    check("bp_awready_full", 34'(s_awready_o), 34'd0);
    check("bp_wready_full",  34'(s_wready_o),  34'd0);
    bready_mode = 0;
    @(negedge clk); #2;
    check("bp_b1_present", 34'(s_bvalid_o), 34'd1);
    @(negedge clk); #2;
    check("bp_b_gap", 34'(s_bvalid_o), 34'd0);
    @(negedge clk); #2;
    check("bp_b2_present", 34'(s_bvalid_o), 34'd1);
    check("bp_awready_free", 34'(s_awready_o), 34'd1);
    check("bp_wready_free",  34'(s_wready_o),  34'd1);
    wait_idle();

    // Commit and AR to the same word on the same edge.
    write_txn(32'h18, 32'h0, 4'hF, 0);
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'h0});
    fork aw_send(32'h18); w_send(32'hA5A5_A5A5, 4'hF); join
    ar_send(32'h18);
    wait_idle();
    ref_mem[6] = 32'hA5A5_A5A5;
    exp_r.push_back({2'b00, 32'hA5A5_A5A5});
    ar_send(32'h18);
    wait_idle();

    // Reset with both holders full and a read response pending.
    rready_mode = 2;
    @(negedge clk);
    ar_send(32'h0);
    @(negedge clk);
    check("rst_mid_rvalid_pending", 34'(s_rvalid_o), 34'd1);
    keep = ref_mem[7];
    fork aw_send(32'h1C); w_send(~keep, 4'hF); join
    @(negedge clk);
    check("rst_mid_aw_full", 34'(s_awready_o), 34'd0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #2;
    check("rst_mid_bvalid", 34'(s_bvalid_o), 34'd0);
    check("rst_mid_rvalid", 34'(s_rvalid_o), 34'd0);
    check("rst_mid_awready", 34'(s_awready_o), 34'd1);
    check("rst_mid_wready",  34'(s_wready_o),  34'd1);
    check("rst_mid_arready", 34'(s_arready_o), 34'd1);
    check("rst_mid_rresp_rdata", {s_rresp_o, s_rdata_o}, 34'd0);
    rready_mode = 0;
    exp_r.push_back({2'b00, keep});
    ar_send(32'h1C);
    wait_idle();

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      bready_mode = $urandom_range(0, 1);
      rready_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: write_txn(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 2));
        1: read_txn(rand_addr());
        default: begin
          widx = $urandom_range(0, DEPTH - 1);
          ridx = (widx + 1 + $urandom_range(0, DEPTH - 2)) % DEPTH;
          d = $urandom;
          fork
            write_issue(BASE + 32'(widx * 4), d, 4'($urandom), $urandom_range(0, 2));
            read_issue(BASE + 32'(ridx * 4));
          join
          wait_idle();
        end
      endcase
    end
    bready_mode = 0;
    rready_mode = 0;
    for (int i = 0; i < DEPTH; i++) read_txn(BASE + 32'(i * 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
